// File: rtl/input_skew_feeder_if.sv
// Handshake and skewed-output bundle between an upstream source, the skew feeder
// and the downstream systolic column shifter.
interface input_skew_feeder_if #(
    parameter int LENGTH     = 4,
    parameter int DATA_WIDTH = 16
);
    logic                         in_valid;
    logic                         in_ready;
    logic                         in_last;
    logic [LENGTH*DATA_WIDTH-1:0] in;
    logic [LENGTH*DATA_WIDTH-1:0] out;
    logic                         out_enable;
    logic [LENGTH-1:0]            out_valid_mask;
    logic                         busy;
    logic                         done;

    modport master (
        output in_valid, in_last, in,
        input  in_ready, out, out_enable, out_valid_mask, busy, done
    );

    modport slave (
        input  in_valid, in_last, in,
        output in_ready, out, out_enable, out_valid_mask, busy, done
    );
endinterface

// File: rtl/input_skew_feeder.sv
// Diagonal skew feeder: lane i is delayed by i extra advance steps; the last vector
// of a tile is followed by LENGTH-1 injected zero vectors so the array drains.
module input_skew_feeder #(
    parameter int LENGTH     = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input_skew_feeder_if.slave  bus
);
    localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            oe_q;
    logic            accept;
    logic            advance;

    assign bus.in_ready = !rst && (state_q != FLUSH);
    assign accept       = bus.in_valid && bus.in_ready;
    assign advance      = accept || (state_q == FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            oe_q    <= advance;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    if (bus.in_last) begin
                        // A single lane needs no drain, so the tile ends on its last accept.
                        if (LENGTH == 1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = FLUSH;
                            cnt_d   = CW'(LENGTH - 1);
                        end
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            FLUSH: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar i = 0; i < LENGTH; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] dat_q [i+1];
        logic [i:0]            msk_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned j = 0; j <= i; j++) begin
                    dat_q[j] <= '0;
                end
                msk_q <= '0;
            end else if (advance) begin
                dat_q[0] <= accept ? bus.in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                msk_q[0] <= accept;
                for (int unsigned j = 1; j <= i; j++) begin
                    dat_q[j] <= dat_q[j-1];
                    msk_q[j] <= msk_q[j-1];
                end
            end
        end

        assign bus.out[i*DATA_WIDTH +: DATA_WIDTH] = dat_q[i];
        assign bus.out_valid_mask[i]              = msk_q[i];
    end

    assign bus.out_enable = oe_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
endmodule

// File: tb/tb_input_skew_feeder.sv
// Bench for input_skew_feeder: a fixed vector table, directed corner sequences and
// randomized traffic checked against a history-window reference model.
module tb_input_skew_feeder;
    localparam int L  = 4;
    localparam int W  = 16;
    localparam int VW = L * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    input_skew_feeder_if #(.LENGTH(L), .DATA_WIDTH(W)) bus ();

    input_skew_feeder #(.LENGTH(L), .DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] pk(input int l3, input int l2, input int l1, input int l0);
        return {W'(l3), W'(l2), W'(l1), W'(l0)};
    endfunction

    // Reference model: the most recent LENGTH stage-0 loads, newest first.
    // Lane i of the output is lane i of the entry i advances old.
    typedef struct {
        logic [VW-1:0] data;
        bit            vld;
    } hent_t;

    hent_t hq[$];
    int    flush_left = 0;
    bit    in_tile    = 1'b0;
    bit    m_oe       = 1'b0;
    bit    m_done     = 1'b0;

    task automatic model_reset();
        hq.delete();
        flush_left = 0;
        in_tile    = 1'b0;
        m_oe       = 1'b0;
        m_done     = 1'b0;
    endtask

    task automatic step(input bit r, input bit v, input bit last, input logic [VW-1:0] d);
        bit            acc, adv;
        hent_t         e;
        logic [VW-1:0] eo;
        logic [L-1:0]  em;
        rst          = r;
        bus.in_valid = v;
        bus.in_last  = last;
        bus.in       = d;
        #1;
        chk("in_ready", VW'(bus.in_ready), VW'(!r && flush_left == 0));
        acc = !r && v && (flush_left == 0);
        adv = !r && (acc || flush_left > 0);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            m_oe   = adv;
            m_done = 1'b0;
            if (acc) begin
                e.data = d;
                e.vld  = 1'b1;
                hq.push_front(e);
                if (last) begin
                    in_tile = 1'b0;
                    if (L == 1) m_done = 1'b1;
                    else        flush_left = L - 1;
                end else begin
                    in_tile = 1'b1;
                end
            end else if (flush_left > 0) begin
                e.data = '0;
                e.vld  = 1'b0;
                hq.push_front(e);
                flush_left--;
                if (flush_left == 0) m_done = 1'b1;
            end
            if (hq.size() > L) void'(hq.pop_back());
        end
        #1;
        eo = '0;
        em = '0;
        for (int i = 0; i < L; i++) begin
            if (i < hq.size()) begin
                eo[i*W +: W] = hq[i].data[i*W +: W];
                em[i]        = hq[i].vld;
            end
        end
        chk("out", bus.out, eo);
        chk("out_valid_mask", VW'(bus.out_valid_mask), VW'(em));
        chk("out_enable", VW'(bus.out_enable), VW'(m_oe));
        chk("done", VW'(bus.done), VW'(m_done));
        chk("busy", VW'(bus.busy), VW'(in_tile || flush_left > 0));
    endtask

    typedef struct {
        bit            v;
        bit            last;
        logic [VW-1:0] d;
        logic [VW-1:0] eout;
        logic [L-1:0]  emask;
        bit            eoe;
        bit            edone;
        bit            erdy;
    } vec_t;

    function automatic vec_t mkv(input bit v, input bit last, input logic [VW-1:0] d,
                                 input logic [VW-1:0] eout, input logic [L-1:0] emask,
                                 input bit eoe, input bit edone, input bit erdy);
        vec_t t;
        t.v = v; t.last = last; t.d = d; t.eout = eout; t.emask = emask;
        t.eoe = eoe; t.edone = edone; t.erdy = erdy;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[8];
        logic [VW-1:0] ones;
        ones = '1;
        // Four-vector tile (lane value 10*v+lane) with in_valid held on 0xFFFF during the drain.
        tbl[0] = mkv(1'b1, 1'b0, pk(3, 2, 1, 0),     pk(0, 0, 0, 0),    4'b0001, 1'b1, 1'b0, 1'b1);
        tbl[1] = mkv(1'b1, 1'b0, pk(13, 12, 11, 10), pk(0, 0, 1, 10),   4'b0011, 1'b1, 1'b0, 1'b1);
        tbl[2] = mkv(1'b1, 1'b0, pk(23, 22, 21, 20), pk(0, 2, 11, 20),  4'b0111, 1'b1, 1'b0, 1'b1);
        tbl[3] = mkv(1'b1, 1'b1, pk(33, 32, 31, 30), pk(3, 12, 21, 30), 4'b1111, 1'b1, 1'b0, 1'b1);
        tbl[4] = mkv(1'b1, 1'b0, ones,               pk(13, 22, 31, 0), 4'b1110, 1'b1, 1'b0, 1'b0);
        tbl[5] = mkv(1'b1, 1'b0, ones,               pk(23, 32, 0, 0),  4'b1100, 1'b1, 1'b0, 1'b0);
        tbl[6] = mkv(1'b1, 1'b0, ones,               pk(33, 0, 0, 0),   4'b1000, 1'b1, 1'b1, 1'b0);
        tbl[7] = mkv(1'b0, 1'b0, ones,               pk(33, 0, 0, 0),   4'b1000, 1'b0, 1'b0, 1'b1);

        bus.in_valid = 1'b1;
        bus.in_last  = 1'b0;
        bus.in       = '1;

        // Reset held two cycles with in_valid asserted, then release.
        step(1'b1, 1'b1, 1'b0, '1);
        step(1'b1, 1'b1, 1'b0, '1);
        step(1'b0, 1'b0, 1'b0, '0);

        for (int i = 0; i < 8; i++) begin
            rst          = 1'b0;
            bus.in_valid = tbl[i].v;
            bus.in_last  = tbl[i].last;
            bus.in       = tbl[i].d;
            #1;
            chk($sformatf("tbl[%0d].in_ready", i), VW'(bus.in_ready), VW'(tbl[i].erdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl[%0d].out", i), bus.out, tbl[i].eout);
            chk($sformatf("tbl[%0d].mask", i), VW'(bus.out_valid_mask), VW'(tbl[i].emask));
            chk($sformatf("tbl[%0d].out_enable", i), VW'(bus.out_enable), VW'(tbl[i].eoe));
            chk($sformatf("tbl[%0d].done", i), VW'(bus.done), VW'(tbl[i].edone));
        end

        // Stall of three cycles mid-tile.
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, pk(3, 2, 1, 0));
        step(1'b0, 1'b1, 1'b0, pk(13, 12, 11, 10));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, pk(99, 99, 99, 99));
        step(1'b0, 1'b1, 1'b0, pk(23, 22, 21, 20));
        step(1'b0, 1'b1, 1'b1, pk(33, 32, 31, 30));
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("stall_lane3_at_done", VW'(bus.out[3*W +: W]), VW'(33));
        chk("stall_done", VW'(bus.done), VW'(1));
        step(1'b0, 1'b0, 1'b0, '0);

        // Reset during the second drain cycle.
        step(1'b0, 1'b1, 1'b0, pk(4, 3, 2, 1));
        step(1'b0, 1'b1, 1'b0, pk(8, 7, 6, 5));
        step(1'b0, 1'b1, 1'b0, pk(12, 11, 10, 9));
        step(1'b0, 1'b1, 1'b1, pk(16, 15, 14, 13));
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("midrst_out", bus.out, '0);
        chk("midrst_mask", VW'(bus.out_valid_mask), '0);
        chk("midrst_busy", VW'(bus.busy), '0);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("midrst_no_done", VW'(bus.done), '0);
        step(1'b0, 1'b1, 1'b0, pk(104, 103, 102, 101));
        step(1'b0, 1'b1, 1'b1, pk(204, 203, 202, 201));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0);

        // Single-vector tile accepted from IDLE.
        step(1'b0, 1'b1, 1'b1, pk(4, 3, 2, 1));
        chk("single_lane0", VW'(bus.out[W-1:0]), VW'(1));
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("single_lane3", VW'(bus.out[3*W +: W]), VW'(4));
        chk("single_done", VW'(bus.done), VW'(1));
        step(1'b0, 1'b0, 1'b0, '0);
        chk("single_idle", VW'(bus.busy), '0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            logic [VW-1:0] d;
            d = {$urandom, $urandom};
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 99) < 15, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
